// File: rtl/pool_fc_pkg.sv
// Shared parameter defaults, mode/state encodings and sizing helpers for the
// pooling + fully-connected engine.
package pool_fc_pkg;

  localparam int DATA_W_DEF  = 69;
  localparam int CH_DEF      = 8;
  localparam int OUT_X_DEF   = 12;
  localparam int OUT_Y_DEF   = 12;
  localparam int CLASSES_DEF = 10;
  localparam int W_W_DEF     = 32;
  localparam int ACC_W_DEF   = 113;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int feat_count(int ch, int ox, int oy);
    return ch * ox * oy;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_fc_if.sv
// Handshake and data bundle between the engine, its window source, weight ROM
// and score consumer. The slave side is the engine.
interface pool_fc_if #(
  parameter int DATA_W  = pool_fc_pkg::DATA_W_DEF,
  parameter int CH      = pool_fc_pkg::CH_DEF,
  parameter int CLASSES = pool_fc_pkg::CLASSES_DEF,
  parameter int W_W     = pool_fc_pkg::W_W_DEF,
  parameter int ACC_W   = pool_fc_pkg::ACC_W_DEF,
  parameter int AW      = pool_fc_pkg::idx_w(pool_fc_pkg::feat_count(
                            pool_fc_pkg::CH_DEF, pool_fc_pkg::OUT_X_DEF, pool_fc_pkg::OUT_Y_DEF))
) ();

  logic                       start;
  logic                       mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [CH*4*DATA_W-1:0]     in_win;
  logic                       w_en;
  logic [AW-1:0]              w_addr;
  logic [CLASSES*W_W-1:0]     w_rdata;
  logic [CLASSES*ACC_W-1:0]   prob;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    output start, mode, in_valid, in_win, w_rdata, out_ready,
    input  in_ready, w_en, w_addr, prob, out_valid, busy
  );

  modport slave (
    input  start, mode, in_valid, in_win, w_rdata, out_ready,
    output in_ready, w_en, w_addr, prob, out_valid, busy
  );

endinterface

// File: rtl/pool_window_reduce.sv
// Combinational 2x2 window reduction for one channel: max (earliest element
// wins ties) or floor average. Zero latency, no flow control.
module pool_window_reduce
  import pool_fc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  pool_mode_e          mode_i,
  input  logic [4*DATA_W-1:0] win_i,
  output logic [DATA_W-1:0]   res_o
);

  logic signed [DATA_W-1:0] elem [4];
  logic signed [DATA_W-1:0] best;
  logic signed [DATA_W+1:0] sum;

  always_comb begin
    for (int i = 0; i < 4; i++) elem[i] = win_i[i*DATA_W +: DATA_W];
    best = elem[0];
    // Strict compare keeps the earlier element on ties.
    for (int i = 1; i < 4; i++) if (elem[i] > best) best = elem[i];
    sum = (DATA_W+2)'(elem[0]) + (DATA_W+2)'(elem[1])
        + (DATA_W+2)'(elem[2]) + (DATA_W+2)'(elem[3]);
    res_o = (mode_i == POOL_AVG) ? sum[DATA_W+1:2] : best;
  end

endmodule

// File: rtl/pool_fc_engine.sv
// Pools CH windows per beat into a feature buffer, then streams the buffer
// against the weight ROM; scores are valid N+2 cycles after the last beat and held until out_ready.
module pool_fc_engine
  import pool_fc_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CH      = CH_DEF,
  parameter int OUT_X   = OUT_X_DEF,
  parameter int OUT_Y   = OUT_Y_DEF,
  parameter int CLASSES = CLASSES_DEF,
  parameter int W_W     = W_W_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic     clk,
  input  logic     rst,
  pool_fc_if.slave bus
);

  localparam int PIX = OUT_X * OUT_Y;
  localparam int N   = feat_count(CH, OUT_X, OUT_Y);
  localparam int AW  = idx_w(N);
  localparam int PW  = idx_w(PIX);
  localparam int CW  = idx_w(CH);

  state_e                   state_q;
  pool_mode_e               mode_q;
  logic                     in_ready_q, w_en_q, out_valid_q, busy_q;
  logic                     acc_vld_q, acc_last_q;
  logic [AW-1:0]            w_addr_q;
  logic [PW-1:0]            wr_pix_q, rd_pix_q;
  logic [CW-1:0]            rd_ch_q, sel_ch_q;
  logic [CH*DATA_W-1:0]     pooled, buf_word_q;
  logic [CH*DATA_W-1:0]     fbuf [PIX];
  logic signed [ACC_W-1:0]  prob_q [CLASSES];
  logic signed [W_W-1:0]    wt [CLASSES];
  logic signed [DATA_W-1:0] feat;

  for (genvar c = 0; c < CH; c++) begin : g_pool
    pool_window_reduce #(.DATA_W(DATA_W)) u_reduce (
      .mode_i (mode_q),
      .win_i  (bus.in_win[c*4*DATA_W +: 4*DATA_W]),
      .res_o  (pooled[c*DATA_W +: DATA_W])
    );
  end

  for (genvar j = 0; j < CLASSES; j++) begin : g_cls
    assign wt[j] = $signed(bus.w_rdata[j*W_W +: W_W]);
    assign bus.prob[j*ACC_W +: ACC_W] = prob_q[j];
  end

  // One word per beat holds all channels, so the buffer keeps a single write port.
  always_ff @(posedge clk) begin
    if (in_ready_q && bus.in_valid) fbuf[wr_pix_q] <= pooled;
    buf_word_q <= fbuf[rd_pix_q];
    sel_ch_q   <= rd_ch_q;
  end

  assign feat = $signed(buf_word_q[int'(sel_ch_q)*DATA_W +: DATA_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= POOL_MAX;
      in_ready_q  <= 1'b0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_vld_q   <= 1'b0;
      acc_last_q  <= 1'b0;
      wr_pix_q    <= '0;
      rd_pix_q    <= '0;
      rd_ch_q     <= '0;
      for (int j = 0; j < CLASSES; j++) prob_q[j] <= '0;
    end else begin
      // Read data for address k lines up with the weights one cycle later.
      acc_vld_q  <= w_en_q;
      acc_last_q <= w_en_q && (w_addr_q == AW'(N-1));
      if (acc_vld_q)
        for (int j = 0; j < CLASSES; j++)
          prob_q[j] <= prob_q[j] + ACC_W'(wt[j]) * ACC_W'(feat);

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q     <= pool_mode_e'(bus.mode);
            for (int j = 0; j < CLASSES; j++) prob_q[j] <= '0;
            state_q    <= S_FILL;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.in_valid) begin
            if (wr_pix_q == PW'(PIX-1)) begin
              wr_pix_q   <= '0;
              in_ready_q <= 1'b0;
              state_q    <= S_MAC;
              w_en_q     <= 1'b1;
              w_addr_q   <= '0;
              rd_pix_q   <= '0;
              rd_ch_q    <= '0;
            end else begin
              wr_pix_q <= wr_pix_q + 1'b1;
            end
          end
        end
        S_MAC: begin
          if (w_en_q) begin
            if (w_addr_q == AW'(N-1)) begin
              w_en_q   <= 1'b0;
              w_addr_q <= '0;
              rd_pix_q <= '0;
              rd_ch_q  <= '0;
            end else begin
              w_addr_q <= w_addr_q + 1'b1;
              if (rd_pix_q == PW'(PIX-1)) begin
                rd_pix_q <= '0;
                rd_ch_q  <= rd_ch_q + 1'b1;
              end else begin
                rd_pix_q <= rd_pix_q + 1'b1;
              end
            end
          end
          if (acc_last_q) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pool_fc_engine.sv
// Randomised and directed checks of pool_fc_engine against a plain-arithmetic
// reference model of pooling and the FC dot products.
module tb_pool_fc_engine;

  localparam int DW  = 16;
  localparam int CHN = 2;
  localparam int PX  = 2;
  localparam int PY  = 2;
  localparam int CL  = 2;
  localparam int WW  = 8;
  localparam int AC  = 32;
  localparam int PIX = PX * PY;
  localparam int N   = CHN * PIX;
  localparam int AW  = 3;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  int win [PIX][CHN][4];
  int wts [N][CL];
  int exp_prob [CL];
  int beat_cyc;
  int addr_log [$];
  int addr_cyc [$];

  pool_fc_if #(.DATA_W(DW), .CH(CHN), .CLASSES(CL), .W_W(WW), .ACC_W(AC), .AW(AW)) bus ();

  pool_fc_engine #(.DATA_W(DW), .CH(CHN), .OUT_X(PX), .OUT_Y(PY),
                   .CLASSES(CL), .W_W(WW), .ACC_W(AC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CL*WW-1:0] rom_word(int k);
    logic [CL*WW-1:0] v;
    v = '0;
    for (int j = 0; j < CL; j++) v[j*WW +: WW] = WW'(wts[k][j]);
    return v;
  endfunction

  // External weight ROM with one cycle of read latency.
  always @(posedge clk) if (bus.w_en === 1'b1) bus.w_rdata <= rom_word(int'(bus.w_addr));

  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      addr_log.push_back(int'(bus.w_addr));
      addr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int prob_of(int j);
    return $signed(bus.prob[j*AC +: AC]);
  endfunction

  function automatic int pool_ref(int m, int a, int b, int c, int d);
    int s, q, mx;
    if (m == 0) begin
      mx = a;
      if (b > mx) mx = b;
      if (c > mx) mx = c;
      if (d > mx) mx = d;
      return mx;
    end
    s = a + b + c + d;
    q = s / 4;
    if ((s % 4) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic void compute_exp(int m);
    int c, p, f;
    for (int j = 0; j < CL; j++) exp_prob[j] = 0;
    for (int k = 0; k < N; k++) begin
      c = k / PIX;
      p = k % PIX;
      f = pool_ref(m, win[p][c][0], win[p][c][1], win[p][c][2], win[p][c][3]);
      for (int j = 0; j < CL; j++) exp_prob[j] += wts[k][j] * f;
    end
  endfunction

  function automatic logic [CHN*4*DW-1:0] pack_win(int p);
    logic [CHN*4*DW-1:0] v;
    v = '0;
    for (int c = 0; c < CHN; c++)
      for (int e = 0; e < 4; e++) v[(4*c+e)*DW +: DW] = DW'(win[p][c][e]);
    return v;
  endfunction

  task automatic set_random();
    for (int p = 0; p < PIX; p++)
      for (int c = 0; c < CHN; c++)
        for (int e = 0; e < 4; e++) win[p][c][e] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < N; k++)
      for (int j = 0; j < CL; j++) wts[k][j] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic set_ramp();
    for (int p = 0; p < PIX; p++)
      for (int c = 0; c < CHN; c++)
        for (int e = 0; e < 4; e++) win[p][c][e] = c*PIX + p + 1;
    for (int k = 0; k < N; k++) begin
      wts[k][0] = 1;
      wts[k][1] = -1;
    end
  endtask

  // All tasks begin and end just after a falling edge.
  task automatic start_img(input int m);
    addr_log.delete();
    addr_cyc.delete();
    bus.mode  = 1'(m);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_ready", bus.in_ready, 1);
    chk("start_busy", bus.busy, 1);
    for (int j = 0; j < CL; j++) chk("start_prob_clear", prob_of(j), 0);
  endtask

  task automatic feed(input int gap_max, input bit poke, input int m);
    for (int p = 0; p < PIX; p++) begin
      repeat ($urandom_range(0, gap_max)) begin
        bus.in_valid = 1'b0;
        bus.start    = poke;
        bus.mode     = 1'(poke ? 1 - m : m);
        @(negedge clk);
      end
      bus.start    = 1'b0;
      bus.mode     = 1'(m);
      bus.in_win   = pack_win(p);
      bus.in_valid = 1'b1;
      chk("fill_in_ready", bus.in_ready, 1);
      beat_cyc = cyc;
      @(negedge clk);
    end
    bus.in_valid = poke;
    bus.in_win   = '1;
  endtask

  task automatic finish_img(input int hold, input bit poke, input int m);
    int n = 0;
    compute_exp(m);
    while (bus.out_valid !== 1'b1 && n < 40) begin
      bus.start = poke;
      bus.mode  = 1'(poke ? 1 - m : m);
      @(negedge clk);
      n++;
    end
    chk("out_valid_latency", cyc - beat_cyc, N + 2);
    chk("w_addr_count", addr_log.size(), N);
    for (int k = 0; k < N && k < addr_log.size(); k++) begin
      chk("w_addr_value", addr_log[k], k);
      chk("w_addr_cycle", addr_cyc[k] - beat_cyc, 1 + k);
    end
    for (int j = 0; j < CL; j++) chk("prob_final", prob_of(j), exp_prob[j]);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      for (int j = 0; j < CL; j++) chk("hold_prob_stable", prob_of(j), exp_prob[j]);
    end
    bus.start     = 1'b0;
    bus.mode      = 1'(m);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_hs_busy", bus.busy, 0);
    chk("post_hs_out_valid", bus.out_valid, 0);
    for (int j = 0; j < CL; j++) chk("post_hs_prob_kept", prob_of(j), exp_prob[j]);
  endtask

  initial begin
    int n;
    bit hit;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_win = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_w_en", bus.w_en, 0);
    chk("rst_w_addr", bus.w_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    for (int j = 0; j < CL; j++) chk("rst_prob", prob_of(j), 0);
    rst = 1'b0;
    @(negedge clk);

    // Max pooling, including tie order and an all-negative window.
    set_random();
    win[0][0] = '{3, -7, 9, 9};
    win[0][1] = '{-5, -2, -8, -3};
    for (int k = 0; k < N; k++) begin
      wts[k][0] = 0;
      wts[k][1] = 0;
    end
    wts[0][0] = 1;
    wts[PIX][1] = 1;
    start_img(0); feed(0, 0, 0); finish_img(0, 0, 0);
    chk("max_tie_value", prob_of(0), 9);
    chk("max_all_negative", prob_of(1), -2);

    // Average pooling with floor rounding; class 0 sums the buffer.
    set_random();
    win[0][0] = '{1, 2, 3, 4};
    win[0][1] = '{-1, -1, -1, -2};
    for (int k = 0; k < N; k++) begin
      wts[k][0] = 1;
      wts[k][1] = 0;
    end
    wts[0][1] = 1;
    wts[PIX][1] = 100;
    start_img(1); feed(0, 0, 1); finish_img(0, 0, 1);
    chk("avg_floor_pair", prob_of(1), -198);

    // Ramp pass 1..8 against +1/-1 weights.
    set_ramp();
    start_img(0); feed(0, 0, 0); finish_img(0, 0, 0);
    chk("ramp_prob0", prob_of(0), 36);
    chk("ramp_prob1", prob_of(1), -36);

    // Random data with input gaps and a stalled consumer.
    for (int i = 0; i < 2; i++) begin
      set_random();
      start_img(i); feed(3, 0, i); finish_img(5, 0, i);
    end

    // Reset mid-MAC, then a clean rerun.
    set_ramp();
    start_img(0); feed(0, 0, 0);
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      if (bus.w_en === 1'b1 && bus.w_addr === 3'd3) hit = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("reach_mac_k3", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_w_en", bus.w_en, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    for (int j = 0; j < CL; j++) chk("midrst_prob", prob_of(j), 0);
    rst = 1'b0;
    start_img(0); feed(1, 0, 0); finish_img(0, 0, 0);
    chk("rerun_prob0", prob_of(0), 36);
    chk("rerun_prob1", prob_of(1), -36);

    // Stray start/mode/in_valid while busy, then a back-to-back image.
    set_random();
    start_img(1); feed(2, 1, 1); finish_img(3, 1, 1);
    set_random();
    start_img(0); feed(0, 0, 0); finish_img(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
